// File: rtl/uart_seq_pkg.sv
// Shared types and ASCII constants for the UART frame sequencer.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StSend,
    StGap,
    StDone
  } state_e;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] EQ    = 8'h3D;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] SEMI  = 8'h3B;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  localparam int unsigned BYTES_PER_CH = 9;

  // Non-BCD nibbles are flagged with '?' rather than emitting ':'..'?' garbage.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d > 4'd9) ? QMARK : (ZERO | {4'h0, d});
  endfunction

endpackage

// File: rtl/frame_period_timer.sv
// Free-running frame period counter with a single sticky trigger flag.
module frame_period_timer #(
  parameter int unsigned PERIOD_CYCLES = 6500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic pending
);

  localparam int unsigned CntW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            wrap;

  // A wrap coinciding with a clear wins, so that trigger is not lost.
  always_comb begin
    wrap      = (cnt_q == CntLast);
    cnt_d     = wrap ? '0 : cnt_q + CntW'(1);
    pending_d = pending_q;
    if (clear) pending_d = 1'b0;
    if (wrap)  pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/uart_frame_sequencer.sv
// Periodically snapshots all BCD channel readings and streams them as one ASCII
// frame into the shared UART transmit FIFO, honouring tx_full per byte.
module uart_frame_sequencer
  import uart_seq_pkg::*;
#(
  parameter int unsigned NCH           = 13,
  parameter int unsigned PERIOD_CYCLES = 6500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [16*NCH-1:0] bcd_in,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned ChW = $clog2(NCH + 1);
  // ch == NCH marks the CR/LF trailer.
  localparam logic [ChW-1:0] ChTail    = ChW'(NCH);
  localparam logic [3:0]     FieldLast = 4'(BYTES_PER_CH - 1);

  state_e            state_q, state_d;
  logic [16*NCH-1:0] snap_q;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        units_q, units_d;
  logic [3:0]        field_q, field_d;
  logic              last_q, last_d;
  logic [7:0]        wdata_q;
  logic [7:0]        cur_byte;
  logic [15:0]       cur_word;
  logic              pending;
  logic              clear;
  logic              load;

  frame_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .pending(pending)
  );

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == ChW'(k)) cur_word = snap_q[16*k +: 16];
    end
  end

  always_comb begin
    cur_byte = LF;
    if (ch_q == ChTail) begin
      cur_byte = (field_q == 4'd0) ? CR : LF;
    end else begin
      case (field_q)
        4'd0:    cur_byte = digit_ascii(tens_q);
        4'd1:    cur_byte = digit_ascii(units_q);
        4'd2:    cur_byte = EQ;
        4'd3:    cur_byte = digit_ascii(cur_word[15:12]);
        4'd4:    cur_byte = DOT;
        4'd5:    cur_byte = digit_ascii(cur_word[11:8]);
        4'd6:    cur_byte = digit_ascii(cur_word[7:4]);
        4'd7:    cur_byte = digit_ascii(cur_word[3:0]);
        default: cur_byte = SEMI;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    tens_d     = tens_q;
    units_d    = units_q;
    field_d    = field_q;
    last_d     = last_q;
    clear      = 1'b0;
    load       = 1'b0;
    wr_uart    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending && enable) begin
          clear   = 1'b1;
          state_d = StLatch;
        end
      end
      StLatch: begin
        busy    = 1'b1;
        load    = 1'b1;
        ch_d    = '0;
        tens_d  = '0;
        units_d = '0;
        field_d = '0;
        last_d  = 1'b0;
        state_d = StSend;
      end
      StSend: begin
        busy = 1'b1;
        if (!tx_full) begin
          wr_uart = 1'b1;
          state_d = StGap;
          if (ch_q == ChTail) begin
            if (field_q == 4'd0) field_d = 4'd1;
            else                 last_d  = 1'b1;
          end else if (field_q == FieldLast) begin
            field_d = '0;
            ch_d    = ch_q + ChW'(1);
            // Channel label counts in BCD so no divider is needed.
            if (units_q == 4'd9) begin
              units_d = '0;
              tens_d  = tens_q + 4'd1;
            end else begin
              units_d = units_q + 4'd1;
            end
          end else begin
            field_d = field_q + 4'd1;
          end
        end
      end
      StGap: begin
        // One idle cycle lets tx_full reflect the byte just written.
        busy    = 1'b1;
        state_d = last_q ? StDone : StSend;
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign w_data = wr_uart ? cur_byte : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      ch_q    <= '0;
      tens_q  <= '0;
      units_q <= '0;
      field_q <= '0;
      last_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      field_q <= field_d;
      last_q  <= last_d;
      if (load)    snap_q  <= bcd_in;
      if (wr_uart) wdata_q <= cur_byte;
    end
  end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Randomised scoreboard bench: a timer/frame model predicts every byte, a
// negedge monitor pops and compares on each wr_uart strobe.
module tb_uart_frame_sequencer;

  localparam int unsigned NCH    = 13;
  localparam int unsigned PERIOD = 400;
  localparam int          FLEN   = 9 * NCH + 2;

  typedef struct packed {
    logic [7:0] b;
    logic       first;
    int         cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [16*NCH-1:0] bcd_in;
  logic              tx_full;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              busy;
  logic              frame_done;

  uart_frame_sequencer #(
    .NCH          (NCH),
    .PERIOD_CYCLES(PERIOD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bcd_in    (bcd_in),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   cyc = 0;
  int   m_cnt = 0;
  bit   m_pending = 0;
  bit   m_latch_next = 0;
  int   m_start_cyc = 0;
  int   m_starts = 0;
  int   m_aborts = 0;
  int   byte_idx = 0;
  int   done_cnt = 0;
  bit   chk_rst = 0;
  bit   mode_chaos = 0;
  bit   mode_rand_full = 0;
  bit   burst_arm = 0;
  int   burst_left = 0;

  function automatic void chk(bit ok, string name, longint act, longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [7:0] asc(int d);
    return (d > 9) ? 8'h3F : 8'(8'h30 + d);
  endfunction

  // Expected frame text derived directly from channel values with plain arithmetic.
  function automatic void push_frame(logic [16*NCH-1:0] v, int first_cyc);
    logic [15:0] w;
    logic [7:0]  fb[9];
    for (int k = 0; k < NCH; k++) begin
      w  = v[16*k +: 16];
      fb = '{asc(k / 10), asc(k % 10), 8'h3D, asc(int'(w[15:12])), 8'h2E,
             asc(int'(w[11:8])), asc(int'(w[7:4])), asc(int'(w[3:0])), 8'h3B};
      for (int j = 0; j < 9; j++)
        exp_q.push_back('{b: fb[j], first: (k == 0 && j == 0), cyc: first_cyc});
    end
    exp_q.push_back('{b: 8'h0D, first: 1'b0, cyc: first_cyc});
    exp_q.push_back('{b: 8'h0A, first: 1'b0, cyc: first_cyc});
  endfunction

  function automatic logic [16*NCH-1:0] rand_bcd(bit allow_bad);
    logic [16*NCH-1:0] v;
    for (int k = 0; k < 4 * NCH; k++)
      v[4*k +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Reference model: period timer, single pending flag, snapshot one cycle after start.
  initial forever begin
    bit wrap, start;
    @(posedge clk);
    cyc++;
    if (rst) begin
      if (exp_q.size() != 0 || m_latch_next) m_aborts++;
      exp_q.delete();
      m_cnt        = 0;
      m_pending    = 0;
      m_latch_next = 0;
    end else begin
      if (m_latch_next) begin
        push_frame(bcd_in, m_start_cyc + 1);
        m_latch_next = 0;
      end
      wrap  = (m_cnt == int'(PERIOD) - 1);
      start = m_pending && enable;
      if (start) begin
        m_pending    = 0;
        m_latch_next = 1;
        m_start_cyc  = cyc;
        m_starts++;
      end
      if (wrap) begin
        m_pending = 1;
        m_cnt     = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  // Monitor: compares every write against the scoreboard head.
  initial forever begin
    exp_t e;
    int   last_wr;
    bit   stalled;
    @(negedge clk);
    if (chk_rst) begin
      chk(!wr_uart, "rst_wr_uart", wr_uart, 0);
      chk(!busy, "rst_busy", busy, 0);
      chk(!frame_done, "rst_frame_done", frame_done, 0);
      chk(w_data == 8'h00, "rst_w_data", w_data, 0);
      chk_rst = 0;
    end
    if (rst) byte_idx = 0;
    if (tx_full) begin
      chk(!wr_uart, "wr_while_full", wr_uart, 0);
      stalled = 1;
    end
    if (wr_uart) begin
      chk(busy, "busy_during_frame", busy, 1);
      if (exp_q.size() == 0) begin
        chk(0, "unexpected_write", w_data, 0);
      end else begin
        e = exp_q.pop_front();
        chk(w_data == e.b, $sformatf("byte%0d", byte_idx), w_data, e.b);
        if (e.first) chk(cyc == e.cyc, "first_byte_cycle", cyc, e.cyc);
        else if (!stalled) chk(cyc - last_wr == 2, "byte_spacing", cyc - last_wr, 2);
      end
      last_wr = cyc;
      stalled = 0;
      byte_idx++;
    end
    if (frame_done) begin
      done_cnt++;
      chk(exp_q.size() == 0, "frame_leftover", exp_q.size(), 0);
      chk(byte_idx == FLEN, "frame_bytes", byte_idx, FLEN);
      chk(!busy, "busy_at_done", busy, 0);
      byte_idx = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (mode_chaos) bcd_in = rand_bcd(1'b1);
    if (mode_rand_full) tx_full = ($urandom_range(0, 9) < 3);
    if (burst_arm && byte_idx >= 30) begin
      burst_arm  = 0;
      burst_left = 50;
    end
    if (burst_left > 0) begin
      tx_full = 1'b1;
      burst_left--;
    end else if (!mode_rand_full) begin
      tx_full = 1'b0;
    end
  endtask

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int i = 0; i < 1500 && done_cnt == start; i++) step();
    chk(done_cnt != start, "frame_timeout", done_cnt, start + 1);
  endtask

  initial begin
    logic [16*NCH-1:0] v;
    rst     = 1'b1;
    enable  = 1'b1;
    tx_full = 1'b0;
    chk_rst = 1'b1;
    for (int k = 0; k < NCH; k++) bcd_in[16*k +: 16] = 16'h1234;
    repeat (3) step();
    rst = 1'b0;

    // Plain frame after first wrap.
    wait_done();

    // Non-BCD nibble on channel 5 plus a 50-cycle full burst mid-frame.
    v = rand_bcd(1'b0);
    v[16*5 +: 16] = 16'h3A01;
    bcd_in    = v;
    burst_arm = 1'b1;
    wait_done();

    // Inputs churn every cycle; only the latched snapshot may appear.
    mode_chaos = 1'b1;
    wait_done();
    mode_chaos = 1'b0;

    // Random backpressure.
    mode_rand_full = 1'b1;
    wait_done();
    mode_rand_full = 1'b0;
    tx_full        = 1'b0;

    // Hold off across two wraps, then enable once shortly after a wrap.
    enable = 1'b0;
    repeat (2 * PERIOD) step();
    for (int i = 0; i < int'(PERIOD) + 5 && m_cnt != 10; i++) step();
    enable = 1'b1;
    wait_done();

    // Abort a frame after byte 40, then expect a clean frame after the next wrap.
    for (int i = 0; i < 1000 && byte_idx < 40; i++) step();
    chk(byte_idx >= 40, "reach_byte40", byte_idx, 40);
    rst = 1'b1;
    step();
    rst     = 1'b0;
    chk_rst = 1'b1;
    wait_done();

    repeat (5) step();
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    chk(done_cnt == m_starts - m_aborts, "frame_count", done_cnt, m_starts - m_aborts);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
